multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core, replacing the single-cycle decoder with one that sequences a shared-memory datapath: PC, IR, ALUOut and the Data register, with one ALU and one unified memory port.
- Decodes the IR fields, drives per-state datapath selects, handshakes with memory and traps on illegal encodings or memory timeout.

Parameters:
- TIMEOUT_CYCLES, 255: maximum memory-wait cycles before a bus-timeout trap; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- Zflag  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a write.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- reg_write  out  1  register-file write.
- ALUSrcA  out  2  ALU operand A: 00 PC, 01 OldPC, 10 rs1, 11 zero.
- ALUSrcB  out  2  ALU operand B: 00 rs2, 01 imm, 10 const 4.
- ALUcontrol  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 srl, 0110 sra, 0111 xor, 1000 slt, 1001 sltu.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- ResultSrc  out  2  Result select: 00 ALUOut, 01 Data, 10 ALUResult.
- load  out  3  load size: 000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu.
- store  out  2  store size: 00 sb, 01 sh, 10 sw.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  FSM is in TRAP.
- trap_cause  out  2  00 none, 01 illegal instruction, 10 bus timeout.

Behaviour:
- Outputs are combinational from the state register, the IR fields and the handshake inputs. Any output not listed for a state is 0.
- Reset: async reset forces RST_IDLE and clears the wait counter and trap_cause. In RST_IDLE every output is 0. The first clock after reset deasserts moves the FSM to FETCH. Reset mid-instruction abandons it with no write issued.
- RST_IDLE -> FETCH.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. While mem_ready=0, hold in FETCH. When mem_ready=1, assert IRWrite and PCWrite and go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add. ImmSrc=011 if op=JAL, else 010. Next state by op:
  - LOAD or STORE -> MEMADR
  - R_TYPE -> EXECR
  - I_TYPE -> EXECI
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI or AUIPC -> UPPER
  - illegal -> TRAP with cause 01
- Illegal encodings:
  - unknown op;
  - R-type with funct7 not in {0, 32};
  - funct7=32 with funct3 not in {0, 5} (R-type) or not 5 (I-type shift);
  - load funct3 in {011, 110, 111};
  - store funct3 >= 3;
  - branch funct3 in {010, 011};
  - JALR funct3 != 0.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. ImmSrc=000 for LOAD, 001 for STORE. Next: MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00, load code valid. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, reg_write=1, load valid, retire=1. Next: FETCH.
- MEMWRITE: mem_req=1, mem_write=1, AdrSrc=1, store valid. Hold until mem_ready. On mem_ready assert retire and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUcontrol from funct3/funct7; funct7=32 selects sub or sra. Next: ALUWB.
- EXECI: as EXECR but ALUSrcB=01, ImmSrc=000, and funct7 is used only for sra. Next: ALUWB.
- UPPER: ALUSrcA=11 for LUI or 01 for AUIPC, ALUSrcB=01, ImmSrc=100, add. Next: ALUWB.
- ALUWB: ResultSrc=00, reg_write=1, retire=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ResultSrc=00. ALUcontrol and PCWrite by funct3:
  - beq: sub, PCWrite=Zflag
  - bne: sub, PCWrite=~Zflag
  - blt: slt, PCWrite=~Zflag
  - bge: slt, PCWrite=Zflag
  - bltu: sltu, PCWrite=~Zflag
  - bgeu: sltu, PCWrite=Zflag
  - retire=1; next: FETCH.
- JAL: ResultSrc=00, PCWrite=1. Next: JLINK.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, add, ResultSrc=10, PCWrite=1. Next: JLINK.
- JLINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, reg_write=1, retire=1. Next: FETCH.
- Latency with zero-wait memory:
  - R-type, I-type, upper, store: 4 cycles
  - load: 5 cycles
  - branch: 3 cycles
  - jump: 4 cycles
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments on each cycle in those states with mem_ready=0.
  - If the count equals TIMEOUT_CYCLES-1 and mem_ready=0, go to TRAP with cause 10.
  - mem_ready=1 in the same cycle wins over the timeout.
- TRAP: halted=1, trap_cause held, all other outputs 0. Only reset leaves TRAP.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALUcontrol, ImmSrc, ResultSrc, ALUSrcA/B, load/store and trap_cause codes;
  - the 16-entry state enum (4 bits).
- Sub-module alu_decoder: combinational. Maps op class, funct3 and funct7 to ALUcontrol plus an illegal flag. Used by EXECR, EXECI and BRANCH.

Test Plan:
- Assert reset mid-MEMREAD -> all outputs 0 immediately, no reg_write. Release reset -> RST_IDLE for 1 cycle, then FETCH with mem_req=1.
- add, then sub (funct7=32), mem_ready tied 1 -> state sequence FETCH, DECODE, EXECR, ALUWB. ALUcontrol=0000 then 0001 in EXECR. reg_write and retire only in ALUWB.
- lw with mem_ready low 3 cycles in MEMREAD -> mem_req held 4 cycles, load=010. MEMWB has ResultSrc=01, reg_write=1. Total 8 cycles.
- beq Zflag=1 -> PCWrite=1 in BRANCH. bne Zflag=1 -> PCWrite=0. bltu -> ALUcontrol=1001. Each retires in 3 cycles.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH -> TRAP after the 4th wait cycle, trap_cause=10, halted=1 persists. mem_ready=1 on the 4th cycle -> DECODE instead.
- op=7'b1111111 -> DECODE then TRAP with cause 01. JAL -> JAL, JLINK: PCWrite then reg_write with ResultSrc=10.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Opcodes, datapath select codes and FSM state encoding shared by the multi-cycle controller.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSll  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluSra  = 4'b0110;
  localparam logic [3:0] AluXor  = 4'b0111;
  localparam logic [3:0] AluSlt  = 4'b1000;
  localparam logic [3:0] AluSltu = 4'b1001;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;
  localparam logic [1:0] SrcAZero  = 2'b11;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [2:0] LdB  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdW  = 3'b010;
  localparam logic [2:0] LdBu = 3'b011;
  localparam logic [2:0] LdHu = 3'b100;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  typedef enum logic [3:0] {
    StRstIdle, StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR,
    StExecI, StUpper, StAluWb, StBranch, StJal, StJalr, StJlink, StTrap
  } state_e;

  typedef enum logic [1:0] {ClsR, ClsI, ClsBranch, ClsNone} op_cls_e;

  // funct3 of a legal load mapped onto the datapath's load-size code.
  function automatic logic [2:0] load_code(logic [2:0] funct3);
    case (funct3)
      3'b001:  return LdH;
      3'b010:  return LdW;
      3'b100:  return LdBu;
      3'b101:  return LdHu;
      default: return LdB;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// IR fields, handshake inputs and datapath controls between controller and datapath.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zflag;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       reg_write;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUcontrol;
  logic [2:0] ImmSrc;
  logic [1:0] ResultSrc;
  logic [2:0] load;
  logic [1:0] store;
  logic       retire;
  logic       halted;
  logic [1:0] trap_cause;

  modport master (
    input  op, funct3, funct7, Zflag, mem_ready,
    output mem_req, mem_write, AdrSrc, IRWrite, PCWrite, reg_write, ALUSrcA, ALUSrcB,
           ALUcontrol, ImmSrc, ResultSrc, load, store, retire, halted, trap_cause
  );

  modport slave (
    output op, funct3, funct7, Zflag, mem_ready,
    input  mem_req, mem_write, AdrSrc, IRWrite, PCWrite, reg_write, ALUSrcA, ALUSrcB,
           ALUcontrol, ImmSrc, ResultSrc, load, store, retire, halted, trap_cause
  );
endinterface

// File: rtl/alu_decoder.sv
// ALU operation decode for R-type, I-type and branch instructions, flagging bad encodings.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  op_cls_e    cls_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  logic alt;  // funct7 = 0100000 selects the sub/sra variant
  assign alt = (funct7_i == 7'b0100000);

  // Operation select and legality from funct3/funct7
  always_comb begin
    alu_ctrl_o = AluAdd;
    illegal_o  = 1'b0;
    case (cls_i)
      ClsR, ClsI: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (cls_i == ClsR && alt) ? AluSub : AluAdd;
          3'b001:  alu_ctrl_o = AluSll;
          3'b010:  alu_ctrl_o = AluSlt;
          3'b011:  alu_ctrl_o = AluSltu;
          3'b100:  alu_ctrl_o = AluXor;
          3'b101:  alu_ctrl_o = alt ? AluSra : AluSrl;
          3'b110:  alu_ctrl_o = AluOr;
          default: alu_ctrl_o = AluAnd;
        endcase
        if (cls_i == ClsR) begin
          illegal_o = !(funct7_i == 7'd0 || alt) ||
                      (alt && funct3_i != 3'b000 && funct3_i != 3'b101);
        end else begin
          // Only the shift-left immediate can carry a bad funct7.
          illegal_o = alt && funct3_i == 3'b001;
        end
      end
      ClsBranch: begin
        case (funct3_i)
          3'b000, 3'b001: alu_ctrl_o = AluSub;
          3'b100, 3'b101: alu_ctrl_o = AluSlt;
          3'b110, 3'b111: alu_ctrl_o = AluSltu;
          default:        illegal_o  = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM sequencing a shared-memory datapath with timeout/illegal traps.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  op_cls_e    op_cls;
  logic [3:0] alu_ctrl;
  logic       alu_illegal;
  logic       dec_illegal;
  logic       wait_state;

  // Class of the current opcode as seen by the ALU decoder
  always_comb begin
    case (bus.op)
      OpR:      op_cls = ClsR;
      OpI:      op_cls = ClsI;
      OpBranch: op_cls = ClsBranch;
      default:  op_cls = ClsNone;
    endcase
  end

  alu_decoder u_alu_decoder (
    .cls_i     (op_cls),
    .funct3_i  (bus.funct3),
    .funct7_i  (bus.funct7),
    .alu_ctrl_o(alu_ctrl),
    .illegal_o (alu_illegal)
  );

  // Full-instruction legality check used in DECODE
  always_comb begin
    case (bus.op)
      OpR, OpI, OpBranch:   dec_illegal = alu_illegal;
      OpLoad:               dec_illegal = bus.funct3 inside {3'b011, 3'b110, 3'b111};
      OpStore:              dec_illegal = bus.funct3 >= 3'd3;
      OpJalr:               dec_illegal = bus.funct3 != 3'b000;
      OpJal, OpLui, OpAuipc: dec_illegal = 1'b0;
      default:              dec_illegal = 1'b1;
    endcase
  end

  assign wait_state = state_q inside {StFetch, StMemRead, StMemWrite};

  // Next state, wait counter, trap cause and per-state datapath controls
  always_comb begin
    state_d        = state_q;
    cnt_d          = '0;
    cause_d        = cause_q;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.ALUSrcA    = SrcAPc;
    bus.ALUSrcB    = SrcBRs2;
    bus.ALUcontrol = AluAdd;
    bus.ImmSrc     = ImmI;
    bus.ResultSrc  = ResAluOut;
    bus.load       = LdB;
    bus.store      = 2'b00;
    bus.retire     = 1'b0;
    bus.halted     = 1'b0;
    bus.trap_cause = cause_q;

    case (state_q)
      StRstIdle: state_d = StFetch;
      StFetch: begin
        bus.mem_req   = 1'b1;
        bus.ALUSrcB   = SrcBFour;
        bus.ResultSrc = ResAluResult;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = StDecode;
        end
      end
      StDecode: begin
        bus.ALUSrcA = SrcAOldPc;
        bus.ALUSrcB = SrcBImm;
        bus.ImmSrc  = (bus.op == OpJal) ? ImmJ : ImmB;
        if (dec_illegal) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else begin
          case (bus.op)
            OpLoad, OpStore: state_d = StMemAdr;
            OpR:             state_d = StExecR;
            OpI:             state_d = StExecI;
            OpBranch:        state_d = StBranch;
            OpJal:           state_d = StJal;
            OpJalr:          state_d = StJalr;
            default:         state_d = StUpper;
          endcase
        end
      end
      StMemAdr: begin
        bus.ALUSrcA = SrcARs1;
        bus.ALUSrcB = SrcBImm;
        bus.ImmSrc  = (bus.op == OpStore) ? ImmS : ImmI;
        state_d     = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.AdrSrc  = 1'b1;
        bus.load    = load_code(bus.funct3);
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        bus.ResultSrc = ResData;
        bus.reg_write = 1'b1;
        bus.load      = load_code(bus.funct3);
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.AdrSrc    = 1'b1;
        bus.store     = bus.funct3[1:0];
        if (bus.mem_ready) begin
          bus.retire = 1'b1;
          state_d    = StFetch;
        end
      end
      StExecR: begin
        bus.ALUSrcA    = SrcARs1;
        bus.ALUcontrol = alu_ctrl;
        state_d        = StAluWb;
      end
      StExecI: begin
        bus.ALUSrcA    = SrcARs1;
        bus.ALUSrcB    = SrcBImm;
        bus.ALUcontrol = alu_ctrl;
        state_d        = StAluWb;
      end
      StUpper: begin
        bus.ALUSrcA = (bus.op == OpLui) ? SrcAZero : SrcAOldPc;
        bus.ALUSrcB = SrcBImm;
        bus.ImmSrc  = ImmU;
        state_d     = StAluWb;
      end
      StAluWb: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA    = SrcARs1;
        bus.ALUcontrol = alu_ctrl;
        // beq/bge/bgeu take on a zero result, bne/blt/bltu on non-zero.
        bus.PCWrite    = bus.Zflag ^ (bus.funct3[0] ^ bus.funct3[2]);
        bus.retire     = 1'b1;
        state_d        = StFetch;
      end
      StJal: begin
        bus.PCWrite = 1'b1;
        state_d     = StJlink;
      end
      StJalr: begin
        bus.ALUSrcA   = SrcARs1;
        bus.ALUSrcB   = SrcBImm;
        bus.ResultSrc = ResAluResult;
        bus.PCWrite   = 1'b1;
        state_d       = StJlink;
      end
      StJlink: begin
        bus.ALUSrcA   = SrcAOldPc;
        bus.ALUSrcB   = SrcBFour;
        bus.ResultSrc = ResAluResult;
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      default: bus.halted = 1'b1;  // StTrap
    endcase

    // Memory wait accounting; a same-cycle mem_ready never reaches this branch.
    if (wait_state && !bus.mem_ready) begin
      cnt_d = cnt_q + 1'b1;
      if (TIMEOUT_CYCLES != 0 && cnt_q == TimeoutLast[CNT_W-1:0]) begin
        state_d = StTrap;
        cause_d = CauseTimeout;
      end
    end
  end

  // State, wait counter and trap cause registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRstIdle;
      cnt_q   <= '0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Instruction-level bench: each instruction expands into an expected per-cycle control trace.
module tb_multicycle_ctrl;

  localparam int Timeout = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [1:0] res;
    logic [2:0] load;
    logic [1:0] store;
    logic       retire;
    logic       halted;
    logic [1:0] cause;
  } ctrl_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .TIMEOUT_CYCLES(Timeout),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int zmode   = -1;  // -1: random Zflag, otherwise forced value
  bit trapped = 0;

  logic  rdy_q[$];
  logic  z_q[$];
  ctrl_t exp_q[$];
  string tag_q[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t observe();
    ctrl_t o;
    o.mem_req   = bus.mem_req;
    o.mem_write = bus.mem_write;
    o.adr_src   = bus.AdrSrc;
    o.ir_write  = bus.IRWrite;
    o.pc_write  = bus.PCWrite;
    o.reg_write = bus.reg_write;
    o.src_a     = bus.ALUSrcA;
    o.src_b     = bus.ALUSrcB;
    o.alu       = bus.ALUcontrol;
    o.imm       = bus.ImmSrc;
    o.res       = bus.ResultSrc;
    o.load      = bus.load;
    o.store     = bus.store;
    o.retire    = bus.retire;
    o.halted    = bus.halted;
    o.cause     = bus.trap_cause;
    return o;
  endfunction

  function automatic logic pick_z();
    return (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference rules for instruction legality
  function automatic bit legal(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    case (op)
      7'h33:               return (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
      7'h13:               return !(f7 == 7'd32 && f3 == 3'd1);
      7'h03:               return !(f3 inside {3'd3, 3'd6, 3'd7});
      7'h23:               return f3 < 3'd3;
      7'h63:               return !(f3 inside {3'd2, 3'd3});
      7'h67:               return f3 == 3'd0;
      7'h6f, 7'h37, 7'h17: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  // ALU code for register/immediate arithmetic: nibble f3 of a lookup word
  function automatic logic [3:0] exp_alu(bit rtype, logic [2:0] f3, logic [6:0] f7);
    logic [31:0] tbl;
    tbl = 32'h2357_9840;
    if (f7 == 7'd32 && f3 == 3'd5) return 4'h6;
    if (rtype && f7 == 7'd32 && f3 == 3'd0) return 4'h1;
    return tbl[f3*4 +: 4];
  endfunction

  function automatic logic [2:0] exp_load(logic [2:0] f3);
    case (f3)
      3'd1:    return 3'd1;
      3'd2:    return 3'd2;
      3'd4:    return 3'd3;
      3'd5:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  task automatic push(string tag, logic rdy, logic z, ctrl_t e);
    tag_q.push_back(tag);
    rdy_q.push_back(rdy);
    z_q.push_back(z);
    exp_q.push_back(e);
  endtask

  task automatic trap(logic [1:0] cause);
    ctrl_t t;
    t        = '0;
    t.halted = 1'b1;
    t.cause  = cause;
    for (int i = 0; i < 3; i++) push("trap", rnd_bit(), rnd_bit(), t);
    trapped = 1;
  endtask

  // A memory phase of `waits` not-ready cycles followed by completion, or a timeout trap.
  task automatic mem_phase(string tag, ctrl_t busy, ctrl_t done, int waits, output bit tr);
    tr = 0;
    for (int i = 0; i < waits && i < Timeout; i++) push(tag, 1'b0, rnd_bit(), busy);
    if (waits >= Timeout) begin
      trap(2'b10);
      tr = 1;
    end else begin
      push(tag, 1'b1, rnd_bit(), done);
    end
  endtask

  task automatic issue(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, int wf, int wm);
    ctrl_t c, d, wb;
    bit    tr;
    logic  z;
    bus.op     = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    c         = '0;
    c.mem_req = 1'b1;
    c.src_b   = 2'b10;
    c.res     = 2'b10;
    d          = c;
    d.ir_write = 1'b1;
    d.pc_write = 1'b1;
    mem_phase("fetch", c, d, wf, tr);
    if (tr) return;
    c       = '0;
    c.src_a = 2'b01;
    c.src_b = 2'b01;
    c.imm   = (op == 7'h6f) ? 3'd3 : 3'd2;
    push("decode", rnd_bit(), rnd_bit(), c);
    if (!legal(op, f3, f7)) begin
      trap(2'b01);
      return;
    end
    wb           = '0;
    wb.reg_write = 1'b1;
    wb.retire    = 1'b1;
    c            = '0;
    case (op)
      7'h03, 7'h23: begin
        c.src_a = 2'b10;
        c.src_b = 2'b01;
        c.imm   = (op == 7'h23) ? 3'd1 : 3'd0;
        push("memadr", rnd_bit(), rnd_bit(), c);
        c         = '0;
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
        if (op == 7'h03) begin
          c.load = exp_load(f3);
          mem_phase("memread", c, c, wm, tr);
          if (tr) return;
          wb.res  = 2'b01;
          wb.load = exp_load(f3);
          push("memwb", rnd_bit(), rnd_bit(), wb);
        end else begin
          c.mem_write = 1'b1;
          c.store     = f3[1:0];
          d           = c;
          d.retire    = 1'b1;
          mem_phase("memwrite", c, d, wm, tr);
        end
      end
      7'h33, 7'h13: begin
        c.src_a = 2'b10;
        c.src_b = (op == 7'h13) ? 2'b01 : 2'b00;
        c.alu   = exp_alu(op == 7'h33, f3, f7);
        push("exec", rnd_bit(), rnd_bit(), c);
        push("aluwb", rnd_bit(), rnd_bit(), wb);
      end
      7'h37, 7'h17: begin
        c.src_a = (op == 7'h37) ? 2'b11 : 2'b01;
        c.src_b = 2'b01;
        c.imm   = 3'd4;
        push("upper", rnd_bit(), rnd_bit(), c);
        push("aluwb", rnd_bit(), rnd_bit(), wb);
      end
      7'h63: begin
        z          = pick_z();
        c.src_a    = 2'b10;
        c.alu      = (f3 < 3'd2) ? 4'h1 : (f3 < 3'd6) ? 4'h8 : 4'h9;
        c.pc_write = (f3 inside {3'd0, 3'd5, 3'd7}) ? z : !z;
        c.retire   = 1'b1;
        push("branch", rnd_bit(), z, c);
      end
      default: begin
        c.pc_write = 1'b1;
        if (op == 7'h67) begin
          c.src_a = 2'b10;
          c.src_b = 2'b01;
          c.res   = 2'b10;
        end
        push("jump", rnd_bit(), rnd_bit(), c);
        wb.src_a = 2'b01;
        wb.src_b = 2'b10;
        wb.res   = 2'b10;
        push("jlink", rnd_bit(), rnd_bit(), wb);
      end
    endcase
  endtask

  // Plays up to max_cycles of the queued trace, then drops whatever is left.
  task automatic run(int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cycles) begin
      bus.mem_ready = rdy_q.pop_front();
      bus.Zflag     = z_q.pop_front();
      #1;
      check(tag_q.pop_front(), 32'(observe()), 32'(exp_q.pop_front()));
      @(negedge clk);
      n++;
    end
    tag_q.delete();
    rdy_q.delete();
    z_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = rnd_bit();
    #1;
    check("reset_zero", 32'(observe()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b0;
    trapped = 0;
    push("rst_idle", rnd_bit(), rnd_bit(), '0);
  endtask

  task automatic go(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, int wf, int wm);
    issue(op, f3, f7, wf, wm);
    run(1000);
    if (trapped) do_reset();
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 31));
    if (r < 16) return 0;
    if (r < 30) return int'($urandom_range(1, 3));
    return Timeout;
  endfunction

  initial begin
    logic [6:0] ops[10];
    logic [6:0] op, f7;
    logic [2:0] f3;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h00};
    bus.op        = '0;
    bus.funct3    = '0;
    bus.funct7    = '0;
    bus.Zflag     = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    go(7'h33, 3'd0, 7'd0, 0, 0);    // add
    go(7'h33, 3'd0, 7'd32, 0, 0);   // sub
    go(7'h03, 3'd2, 7'd0, 0, 3);    // lw, 3 wait cycles
    issue(7'h03, 3'd2, 7'd0, 0, 3); // lw abandoned mid-MEMREAD
    run(5);
    do_reset();
    zmode = 1;
    go(7'h63, 3'd0, 7'd0, 0, 0);    // beq taken
    go(7'h63, 3'd1, 7'd0, 0, 0);    // bne not taken
    zmode = -1;
    go(7'h63, 3'd6, 7'd0, 0, 0);    // bltu
    go(7'h13, 3'd0, 7'd0, Timeout, 0);
    go(7'h13, 3'd0, 7'd0, Timeout - 1, 0);
    go(7'h7f, 3'd0, 7'd0, 0, 0);
    go(7'h6f, 3'd0, 7'd0, 0, 0);
    go(7'h23, 3'd2, 7'd0, 0, Timeout);

    for (int k = 0; k < 200; k++) begin
      op = ops[$urandom_range(0, 9)];
      if (op == 7'h00) op = 7'($urandom);
      f3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       f7 = 7'd0;
        1:       f7 = 7'd32;
        default: f7 = 7'($urandom);
      endcase
      if (op == 7'h13 && f7 == 7'd32 && f3 != 3'd1 && f3 != 3'd5) f7 = 7'd0;
      go(op, f3, f7, pick_wait(), pick_wait());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
